// File: rtl/fifo_pkg.sv
// Shared constants, types and index helpers for the FIFO read-side stream adapter.
package fifo_pkg;

    localparam int FIFO_BUF_DEPTH = 3;
    localparam int LEVEL_W        = 2;

    typedef logic [1:0]         buf_idx_t;
    typedef logic [LEVEL_W-1:0] level_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_e;

    // Buffer indices wrap 2 -> 0; value 3 is never produced.
    function automatic buf_idx_t idx_inc(input buf_idx_t idx);
        buf_idx_t nxt;
        if (idx == 2'd2) begin
            nxt = 2'd0;
        end else begin
            nxt = idx + 2'd1;
        end
        return nxt;
    endfunction

    function automatic occ_e occ_of(input level_t lvl);
        occ_e occ;
        case (lvl)
            2'd0:    occ = OCC_EMPTY;
            2'd3:    occ = OCC_FULL;
            default: occ = OCC_PARTIAL;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready output stream carrying first-word-fall-through FIFO data.
interface fifo_rd_stream_if #(
    parameter int WIDTH = 8
);
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/fifo_buf3.sv
// Three-entry register array: one synchronous write port, one asynchronous read port.
module fifo_buf3
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             we_i,
    input  buf_idx_t         waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  buf_idx_t         raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [FIFO_BUF_DEPTH];

    // Entry storage; contents carry no reset because they are only read while valid.
    always_ff @(posedge clk) begin
        if (we_i) begin
            case (waddr_i)
                2'd0:    mem_q[0] <= wdata_i;
                2'd1:    mem_q[1] <= wdata_i;
                2'd2:    mem_q[2] <= wdata_i;
                default: ;
            endcase
        end
    end

    // Head word read-out.
    always_comb begin
        rdata_o = '0;
        case (raddr_i)
            2'd0:    rdata_o = mem_q[0];
            2'd1:    rdata_o = mem_q[1];
            2'd2:    rdata_o = mem_q[2];
            default: rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Converts the FIFO read-pointer pop interface and 1-cycle memory read into a
// first-word-fall-through valid/ready stream using a credit-managed 3-entry buffer.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int BUF_DEPTH = FIFO_BUF_DEPTH
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     empty_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         rd_data_i,
    output logic                     en_o,
    fifo_rd_stream_if.master         m_if,
    output level_t                   level_o,
    output logic                     ovf_err_o
);

    logic             inflight_q;
    level_t           level_q,  level_d;
    buf_idx_t         head_q,   head_d;
    buf_idx_t         tail_q,   tail_d;
    occ_e             occ_q,    occ_d;
    logic             m_valid_q;
    logic             ovf_err_q;

    logic             drain_s;
    logic             full_s;
    logic             ovf_s;
    logic             capture_s;
    logic [2:0]       credit_sum_s;
    logic [WIDTH-1:0] buf_rdata_s;
    logic             unused_empty_s;

    // The upstream stage already gates pop with empty, so the flag is informational here.
    assign unused_empty_s = empty_i;

    // Credit check uses registered terms only, so m_ready never reaches the pop request.
    assign credit_sum_s = {1'b0, level_q} + {2'b00, inflight_q};
    assign en_o         = ~arst & (credit_sum_s < BUF_DEPTH[2:0]);

    // Capture, drain and next-state pointer/level computation.
    always_comb begin
        drain_s   = m_valid_q & m_if.m_ready;
        full_s    = (occ_q == OCC_FULL);
        ovf_s     = inflight_q & full_s & ~drain_s;
        capture_s = inflight_q & ~ovf_s;

        case ({capture_s, drain_s})
            2'b10:   level_d = level_q + 2'd1;
            2'b01:   level_d = level_q - 2'd1;
            default: level_d = level_q;
        endcase

        if (drain_s) begin
            head_d = idx_inc(head_q);
        end else begin
            head_d = head_q;
        end

        if (capture_s) begin
            tail_d = idx_inc(tail_q);
        end else begin
            tail_d = tail_q;
        end

        occ_d = occ_of(level_d);
    end

    // Occupancy FSM with registered stream outputs and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (arst) begin
            inflight_q <= 1'b0;
            level_q    <= 2'd0;
            head_q     <= 2'd0;
            tail_q     <= 2'd0;
            occ_q      <= OCC_EMPTY;
            m_valid_q  <= 1'b0;
            ovf_err_q  <= 1'b0;
        end else begin
            inflight_q <= pop_i;
            level_q    <= level_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            m_valid_q  <= (occ_d != OCC_EMPTY);
            ovf_err_q  <= ovf_err_q | ovf_s;
        end
    end

    fifo_buf3 #(
        .WIDTH   (WIDTH)
    ) u_buf (
        .clk     (clk),
        .we_i    (capture_s & ~arst),
        .waddr_i (tail_q),
        .wdata_i (rd_data_i),
        .raddr_i (head_q),
        .rdata_o (buf_rdata_s)
    );

    assign m_if.m_valid = m_valid_q;
    assign m_if.m_data  = buf_rdata_s;
    assign level_o      = level_q;
    assign ovf_err_o    = ovf_err_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: queue-based upstream FIFO and output-buffer model.
module tb_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       arst;
    logic       empty_i;
    logic       pop_i;
    logic [7:0] rd_data_i;
    logic       en_o;
    logic [1:0] level_o;
    logic       ovf_err_o;

    fifo_rd_stream_if #(.WIDTH(8)) m_if ();

    fifo_rd_stream #(
        .WIDTH     (8),
        .BUF_DEPTH (3)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .empty_i   (empty_i),
        .pop_i     (pop_i),
        .rd_data_i (rd_data_i),
        .en_o      (en_o),
        .m_if      (m_if),
        .level_o   (level_o),
        .ovf_err_o (ovf_err_o)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    bit         chk_on = 1'b0;
    event       chk_ev;

    logic [7:0] up_q[$];
    logic [7:0] mq[$];
    logic [7:0] acc_q[$];
    int         acc_cyc[$];
    logic       m_inf  = 1'b0;
    logic [7:0] m_word = 8'h00;
    logic       m_ovf  = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // One clock cycle: drive upstream and consumer, then advance the model.
    task automatic step(input logic a, input logic rdy, input logic fpop);
        logic [7:0] pw;
        logic       dr;
        int         pre;
        @(negedge clk);
        arst         = a;
        m_if.m_ready = rdy;
        if (a) up_q.delete();
        empty_i   = (up_q.size() == 0);
        rd_data_i = m_word;
        #1;
        pop_i = fpop | (en_o & ~empty_i);
        pw    = 8'hEE;
        if (pop_i && up_q.size() != 0) pw = up_q.pop_front();
        @(posedge clk);
        cyc++;
        if (a) begin
            mq.delete();
            m_ovf = 1'b0;
            m_inf = 1'b0;
        end else begin
            pre = mq.size();
            dr  = (pre != 0) && rdy;
            if (dr) begin
                acc_q.push_back(mq.pop_front());
                acc_cyc.push_back(cyc);
            end
            if (m_inf) begin
                if (pre == 3 && !dr) m_ovf = 1'b1;
                else mq.push_back(m_word);
            end
            m_inf = pop_i;
        end
        m_word = pw;
        #1;
        ->chk_ev;
    endtask

    // Per-cycle comparison of all registered outputs against the model.
    always @(chk_ev) begin
        if (chk_on) begin
            chk("level", 32'(level_o), 32'(mq.size()));
            chk("m_valid", 32'(m_if.m_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) chk("m_data", 32'(m_if.m_data), 32'(mq[0]));
            chk("ovf_err", 32'(ovf_err_o), 32'(m_ovf));
            chk("en", 32'(en_o), 32'(!arst && (mq.size() + int'(m_inf) < 3)));
        end
    end

    initial begin
        int n;
        arst         = 1'b1;
        m_if.m_ready = 1'b0;
        empty_i      = 1'b1;
        pop_i        = 1'b0;
        rd_data_i    = 8'h00;

        step(1'b1, 1'b0, 1'b0);
        chk_on = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_valid", 32'(m_if.m_valid), 32'd0);
        chk("rst_en", 32'(en_o), 32'd0);
        chk("rst_ovf", 32'(ovf_err_o), 32'd0);

        // Three preloaded words, consumer always ready.
        up_q = '{8'h11, 8'h22, 8'h33};
        n = cyc + 1;
        repeat (6) step(1'b0, 1'b1, 1'b0);
        chk("t1_count", 32'(acc_q.size()), 32'd3);
        chk("t1_w0", 32'(acc_q[0]), 32'h11);
        chk("t1_w1", 32'(acc_q[1]), 32'h22);
        chk("t1_w2", 32'(acc_q[2]), 32'h33);
        chk("t1_lat", 32'(acc_cyc[0] - n), 32'd2);
        chk("t1_c1", 32'(acc_cyc[1] - n), 32'd3);
        chk("t1_c2", 32'(acc_cyc[2] - n), 32'd4);
        chk("t1_level", 32'(level_o), 32'd0);
        acc_q.delete();
        acc_cyc.delete();

        // Ten words, consumer stalled: buffer fills and credit stops popping.
        for (int i = 0; i < 10; i++) up_q.push_back(8'hA0 + 8'(i));
        repeat (8) step(1'b0, 1'b0, 1'b0);
        chk("t2_level", 32'(level_o), 32'd3);
        chk("t2_en", 32'(en_o), 32'd0);
        chk("t2_ovf", 32'(ovf_err_o), 32'd0);
        chk("t2_head", 32'(m_if.m_data), 32'hA0);
        chk("t2_left", 32'(up_q.size()), 32'd7);

        // Ready toggles 1,0,1,1 then stays high until all ten drain.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        repeat (14) step(1'b0, 1'b1, 1'b0);
        chk("t3_count", 32'(acc_q.size()), 32'd10);
        for (int i = 0; i < 10; i++) chk("t3_word", 32'(acc_q[i]), 32'hA0 + 32'(i));
        chk("t3_level", 32'(level_o), 32'd0);
        acc_q.delete();
        acc_cyc.delete();

        // Long stream: one word per cycle after start-up.
        for (int i = 0; i < 30; i++) up_q.push_back(8'(i * 7 + 3));
        n = cyc + 1;
        repeat (34) step(1'b0, 1'b1, 1'b0);
        chk("t4_count", 32'(acc_q.size()), 32'd30);
        chk("t4_start", 32'(acc_cyc[0] - n), 32'd2);
        for (int i = 1; i < 30; i++) chk("t4_rate", 32'(acc_cyc[i] - acc_cyc[0]), 32'(i));
        chk("t4_last", 32'(acc_q[29]), 32'd206);
        acc_q.delete();
        acc_cyc.delete();

        // Reset while two words are buffered and one is in flight.
        for (int i = 0; i < 5; i++) up_q.push_back(8'hC0 + 8'(i));
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("t5_pre_level", 32'(level_o), 32'd2);
        step(1'b1, 1'b0, 1'b0);
        chk("t5_level", 32'(level_o), 32'd0);
        chk("t5_valid", 32'(m_if.m_valid), 32'd0);
        chk("t5_en", 32'(en_o), 32'd0);
        up_q = '{8'h51, 8'h52, 8'h53};
        repeat (7) step(1'b0, 1'b1, 1'b0);
        chk("t5_count", 32'(acc_q.size()), 32'd3);
        chk("t5_w0", 32'(acc_q[0]), 32'h51);
        chk("t5_w2", 32'(acc_q[2]), 32'h53);
        acc_q.delete();
        acc_cyc.delete();

        // Forced pop into a full buffer trips the sticky overflow flag.
        up_q = '{8'h61, 8'h62, 8'h63};
        repeat (5) step(1'b0, 1'b0, 1'b0);
        chk("t6_full", 32'(level_o), 32'd3);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("t6_ovf", 32'(ovf_err_o), 32'd1);
        repeat (5) step(1'b0, 1'b1, 1'b0);
        chk("t6_sticky", 32'(ovf_err_o), 32'd1);
        chk("t6_count", 32'(acc_q.size()), 32'd3);
        chk("t6_w2", 32'(acc_q[2]), 32'h63);
        step(1'b1, 1'b0, 1'b0);
        chk("t6_clear", 32'(ovf_err_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
